key_schedule_store: RTL and testbench
=====================================

KEY_SCHEDULE_STORE -- requirements
Module: key_schedule_store

Interface
REQ-001 SHALL have parameter MAX_NK, default 8, meaning the largest supported key length in 32-bit words (4, 6 or 8); the round-key store holds 4*(MAX_NK+7) words.
REQ-002 SHALL have port CLK, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST_N, input, 1, meaning the asynchronous active-low reset.
REQ-004 SHALL have port LOAD, input, 1, meaning: capture key and mode, then start expansion.
REQ-005 SHALL have port mode, input, 2, meaning the key size: 0=128, 1=192, 2=256, 3=illegal.
REQ-006 SHALL have port key, input, [0:255], meaning the cipher key, MSB-first; a 128-bit key is key[0:127] and a 192-bit key is key[0:191].
REQ-007 SHALL have port REVERS, input, 1, meaning the stream direction, sampled on start: 0 = round 0..Nr, 1 = round Nr..0.
REQ-008 SHALL have port start, input, 1, meaning a request to begin one round-key stream.
REQ-009 SHALL have port rk_ready, input, 1, meaning the consumer accepts rk this cycle.
REQ-010 SHALL have port busy, output, 1, meaning expansion is in progress.
REQ-011 SHALL have port key_ready, output, 1, meaning the store holds a complete schedule.
REQ-012 SHALL have port err, output, 1, meaning the last LOAD was rejected.
REQ-013 SHALL have port rk_valid, output, 1, meaning rk is valid.
REQ-014 SHALL have port rk, output, [0:127], meaning the round key, words w[4r]..w[4r+3], MSB-first.
REQ-015 SHALL have port rk_round, output, 4, meaning the round index r of rk.
REQ-016 SHALL have port rk_last, output, 1, meaning rk is the final key of the stream.

Function
REQ-017 SHALL implement the FSM IDLE -> EXPAND -> READY <-> STREAM.
REQ-018 LOAD SHALL be honoured in every state, with priority over start and over any stream in progress; it aborts any expansion or stream, drops rk_valid and key_ready on the next cycle, and clears err.
REQ-019 LOAD with mode=3, or with Nk > MAX_NK, SHALL set err=1 and go to IDLE with key_ready=0.
REQ-020 In EXPAND, SHALL write w[0..Nk-1] from key on the LOAD edge, then compute one word per cycle for i=Nk..4(Nr+1)-1 per FIPS-197: RotWord+SubWord+Rcon when i mod Nk=0; SubWord only when Nk=8 and i mod 8=4.
REQ-021 Expansion latency from the LOAD edge to key_ready=1 SHALL be 40/46/52 cycles for 128/192/256, with busy=1 for exactly those cycles.
REQ-022 Rcon SHALL be generated iteratively by xtime from 01, with no table beyond 10 entries.
REQ-023 start SHALL be ignored unless the FSM is in READY and LOAD=0; in READY, start moves to STREAM and raises rk_valid on the next cycle with r=0 (REVERS=0) or r=Nr (REVERS=1).
REQ-024 A transfer SHALL occur when rk_valid && rk_ready; the next key follows in the next cycle (r+1 or r-1), giving one key per cycle under continuous ready.
REQ-025 While rk_valid && !rk_ready, rk, rk_round and rk_last SHALL hold stable.
REQ-026 rk_last SHALL be 1 when r=Nr (forward) or r=0 (reverse); after the last transfer, rk_valid goes to 0 and the FSM returns to READY with the store intact, so repeated streams are allowed.
REQ-027 Nr SHALL be 10/12/14 and rk_round SHALL never leave 0..Nr.

Reset
REQ-028 While RST_N=0, the FSM SHALL be IDLE and busy, key_ready, err, rk_valid, rk_last, rk_round and rk SHALL all be 0; store contents are don't-care; reset may assert mid-expansion or mid-stream.

Verification
REQ-029 mode=0, key 2b7e151628aed2a6abf7158809cf4f3c, LOAD, start, REVERS=0, rk_ready=1 -> key_ready after 40 cycles; r0=key; r1=a0fafe1788542cb123a339392a6c7605; r10=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1; 11 transfers total.
REQ-030 The same key with REVERS=1 and rk_ready toggling every cycle -> first key r10 d014f9a8..., last key r0 with rk_last=1, and rk held stable in every stalled cycle.
REQ-031 mode=1, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> key_ready after 46 cycles; r12=e98ba06f448c773c8ecc720401002202.
REQ-032 mode=2, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> key_ready after 52 cycles; r14=fe4890d1e6188d0b046df344706c631e.
REQ-033 A new LOAD mid-stream, then a second LOAD with mode=3 -> rk_valid=0 on the next cycle; err=1 and key_ready=0 after the second LOAD; start is ignored.
REQ-034 RST_N pulsed low mid-expansion -> all outputs 0 asynchronously; a subsequent LOAD gives correct keys.

Source files
------------

// File: rtl/key_schedule_store.sv
// rtl/key_schedule_store.sv - AES key expansion into a round-key store with a round-key stream readout
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   LOAD, mode, key   capture a 128/192/256-bit key and expand it (mode 3 is rejected)
//   REVERS, start     begin one round-key stream, forward (0) or reverse (1)
//   rk_ready          consumer accepts rk this cycle
//   busy, key_ready   expansion running / complete schedule held
//   err               last LOAD was rejected
//   rk_valid, rk, rk_round, rk_last   round-key stream
module key_schedule_store #(
    parameter int MAX_NK = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         LOAD,
    input  logic [1:0]   mode,
    input  logic [0:255] key,
    input  logic         REVERS,
    input  logic         start,
    input  logic         rk_ready,
    output logic         busy,
    output logic         key_ready,
    output logic         err,
    output logic         rk_valid,
    output logic [0:127] rk,
    output logic [3:0]   rk_round,
    output logic         rk_last
);
    localparam int         DEPTH    = 4 * (MAX_NK + 7);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY, S_STREAM} state_t;
    state_t r_state, w_next;

    logic [31:0]   r_store [0:DEPTH-1];
    logic [AW-1:0] r_idx;       // word index being computed during EXPAND
    logic [3:0]    r_mod;       // r_idx mod Nk, tracked incrementally
    logic [3:0]    r_nk;
    logic [3:0]    r_round;
    logic [7:0]    r_rcon;
    logic          r_rev;
    logic          r_valid;
    logic          r_last;
    logic          r_err;
    logic [0:127]  r_rk;

    logic [3:0]    w_load_nk, w_nr, w_step, w_rd_round;
    logic          w_load_bad;
    logic [AW-1:0] w_last_idx, w_rd_base;
    logic [31:0]   w_prev, w_temp, w_new;
    logic [0:127]  w_rd_rk;

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sub_byte(x[31:24]), sub_byte(x[23:16]), sub_byte(x[15:8]), sub_byte(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        w_load_nk  = (mode == 2'd0) ? 4'd4 : (mode == 2'd1) ? 4'd6 : 4'd8;
        w_load_bad = (mode == 2'd3) || (w_load_nk > MAX_NK_L);
        w_nr       = r_nk + 4'd6;
        w_last_idx = AW'({w_nr, 2'b11});
        w_prev     = r_store[r_idx - AW'(1)];
        w_temp     = w_prev;
        if (r_mod == 4'd0)
            w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
        else if (r_nk == 4'd8 && r_mod == 4'd4)
            w_temp = sub_word(w_prev);
        w_new      = r_store[r_idx - AW'(r_nk)] ^ w_temp;
        w_step     = r_rev ? r_round - 4'd1 : r_round + 4'd1;
        // In READY the read port pre-fetches the first key of the stream about to start.
        w_rd_round = (r_state == S_STREAM) ? w_step : (REVERS ? w_nr : 4'd0);
        w_rd_base  = AW'({w_rd_round, 2'b00});
        w_rd_rk    = {r_store[w_rd_base], r_store[w_rd_base + AW'(1)],
                      r_store[w_rd_base + AW'(2)], r_store[w_rd_base + AW'(3)]};
    end

    always_comb begin
        w_next = r_state;
        if (LOAD) begin
            w_next = w_load_bad ? S_IDLE : S_EXPAND;
        end else begin
            case (r_state)
                S_EXPAND: if (r_idx == w_last_idx) w_next = S_READY;
                S_READY:  if (start) w_next = S_STREAM;
                S_STREAM: if (r_valid && rk_ready && r_last) w_next = S_READY;
                default:  w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_idx   <= '0;
            r_mod   <= 4'd0;
            r_nk    <= 4'd4;
            r_rcon  <= 8'h01;
            r_rev   <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
            r_round <= 4'd0;
            r_rk    <= '0;
        end else if (LOAD) begin
            r_err   <= w_load_bad;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_nk    <= w_load_nk;
            r_idx   <= AW'(w_load_nk);
            r_mod   <= 4'd0;
            r_rcon  <= 8'h01;
        end else begin
            case (r_state)
                S_EXPAND: begin
                    r_idx <= r_idx + AW'(1);
                    r_mod <= (r_mod == r_nk - 4'd1) ? 4'd0 : r_mod + 4'd1;
                    if (r_mod == 4'd0) r_rcon <= xtime(r_rcon);
                end
                S_READY: begin
                    if (start) begin
                        r_rev   <= REVERS;
                        r_round <= w_rd_round;
                        r_rk    <= w_rd_rk;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (r_valid && rk_ready) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                        end else begin
                            r_round <= w_step;
                            r_rk    <= w_rd_rk;
                            r_last  <= r_rev ? (w_step == 4'd0) : (w_step == w_nr);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Store contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (LOAD) begin
            for (int j = 0; j < MAX_NK; j++)
                r_store[AW'(j)] <= key[8'(32 * j) +: 32];
        end else if (r_state == S_EXPAND) begin
            r_store[r_idx] <= w_new;
        end
    end

    assign busy      = (r_state == S_EXPAND);
    assign key_ready = (r_state == S_READY) || (r_state == S_STREAM);
    assign err       = r_err;
    assign rk_valid  = r_valid;
    assign rk        = r_rk;
    assign rk_round  = r_round;
    assign rk_last   = r_last;
endmodule

// File: tb/tb_key_schedule_store.sv
// tb/tb_key_schedule_store.sv - self-checking bench for key_schedule_store
module tb_key_schedule_store;
    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         LOAD = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [0:255] key = '0;
    logic         REVERS = 1'b0;
    logic         start = 1'b0;
    logic         rk_ready = 1'b0;
    logic         busy, key_ready, err, rk_valid, rk_last;
    logic [0:127] rk;
    logic [3:0]   rk_round;

    int           n_pass = 0;
    int           n_total = 0;
    int           nk_cur = 4;
    logic [7:0]   sb_tab [0:255];
    logic [31:0]  mw [0:59];
    logic [0:127] got [0:14];

    key_schedule_store #(.MAX_NK(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .mode(mode), .key(key),
        .REVERS(REVERS), .start(start), .rk_ready(rk_ready), .busy(busy),
        .key_ready(key_ready), .err(err), .rk_valid(rk_valid), .rk(rk),
        .rk_round(rk_round), .rk_last(rk_last)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (b != 0 && gmul(8'(b), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb_tab[x[31:24]], sb_tab[x[23:16]], sb_tab[x[15:8]], sb_tab[x[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input int j);
        logic [7:0] p;
        p = 8'h01;
        for (int k = 1; k < j; k++) p = gmul(p, 8'h02);
        return p;
    endfunction

    task automatic model_expand(input logic [1:0] m, input logic [0:255] k);
        int nk;
        int nw;
        logic [31:0] t;
        nk = (m == 2'd0) ? 4 : (m == 2'd1) ? 6 : 8;
        nw = 4 * (nk + 7);
        nk_cur = nk;
        for (int j = 0; j < nk; j++) mw[j] = k[32 * j +: 32];
        for (int i = nk; i < nw; i++) begin
            t = mw[i - 1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon(i / nk), 24'h0};
            else if (nk == 8 && i % 8 == 4) t = subw(t);
            mw[i] = mw[i - nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model_rk(input int r);
        return {mw[4 * r], mw[4 * r + 1], mw[4 * r + 2], mw[4 * r + 3]};
    endfunction

    task automatic do_load(input logic [1:0] m, input logic [0:255] k, input int exp_lat,
                           input logic with_start, input string tag);
        int lat;
        int bsy;
        lat = 0;
        bsy = 0;
        model_expand(m, k);
        mode = m;
        key = k;
        LOAD = 1'b1;
        start = with_start;
        REVERS = 1'b0;
        @(posedge CLK); #1;
        LOAD = 1'b0;
        start = 1'b0;
        check({tag, " valid after load"}, 128'(rk_valid), 128'(0));
        while (!key_ready && lat < 100) begin
            if (busy) bsy++;
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'(exp_lat));
        check({tag, " busy cycles"}, 128'(bsy), 128'(exp_lat));
        check({tag, " busy/err at ready"}, 128'({busy, err}), 128'(0));
    endtask

    // rmode: 0 = always ready, 1 = toggling (stall first), 2 = random
    task automatic do_stream(input logic rev, input int rmode, input string tag);
        int nr;
        int exp_r;
        int end_r;
        int xfers;
        int cyc;
        logic done;
        logic prev_stall;
        logic [131:0] prev;
        nr = nk_cur + 6;
        exp_r = rev ? nr : 0;
        end_r = rev ? 0 : nr;
        xfers = 0;
        cyc = 0;
        done = 1'b0;
        prev_stall = 1'b0;
        prev = '0;
        REVERS = rev;
        start = 1'b1;
        rk_ready = 1'b0;
        @(posedge CLK); #1;
        start = 1'b0;
        check({tag, " first valid"}, 128'(rk_valid), 128'(1));
        while (!done && cyc < 200 && rk_valid) begin
            cyc++;
            if (prev_stall)
                check({tag, " stable in stall"}, 128'({rk_last, rk_round, rk}), 128'(prev));
            check({tag, " rk"}, rk, model_rk(exp_r));
            check({tag, " round/last"}, 128'({rk_round, rk_last}), 128'({4'(exp_r), exp_r == end_r}));
            got[exp_r] = rk;
            prev = {rk_last, rk_round, rk};
            case (rmode)
                0:       rk_ready = 1'b1;
                1:       rk_ready = (cyc % 2 == 0);
                default: rk_ready = 1'($urandom_range(0, 1));
            endcase
            prev_stall = !rk_ready;
            if (rk_ready) begin
                xfers++;
                if (exp_r == end_r) done = 1'b1;
                else exp_r = rev ? exp_r - 1 : exp_r + 1;
            end
            @(posedge CLK); #1;
        end
        rk_ready = 1'b0;
        check({tag, " transfers"}, 128'(xfers), 128'(nr + 1));
        check({tag, " end valid/ready"}, 128'({rk_valid, key_ready}), 128'(2'b01));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " flags"}, 128'({busy, key_ready, err, rk_valid, rk_last}), 128'(0));
        check({tag, " rk_round"}, 128'(rk_round), 128'(0));
        check({tag, " rk"}, rk, 128'(0));
    endtask

    logic [0:255] k128, k192, k256, kr;

    initial begin
        build_sbox();
        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        RST_N = 1'b1;
        @(posedge CLK); #1;

        do_load(2'd0, k128, 40, 1'b0, "k128");
        do_stream(1'b0, 0, "k128 fwd");
        check("k128 r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("k128 r1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("k128 r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        do_stream(1'b1, 1, "k128 rev");
        check("k128 rev r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("k128 rev r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        do_load(2'd1, k192, 46, 1'b1, "k192");
        do_stream(1'b0, 2, "k192 fwd");
        check("k192 r12", got[12], 128'he98ba06f448c773c8ecc720401002202);

        do_load(2'd2, k256, 52, 1'b0, "k256");
        do_stream(1'b1, 2, "k256 rev");
        check("k256 r14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        for (int n = 0; n < 4; n++) begin
            kr = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            mode = 2'($urandom_range(0, 2));
            do_load(mode, kr, 40 + 6 * int'(mode), 1'($urandom_range(0, 1)), "rand");
            do_stream(1'($urandom_range(0, 1)), 2, "rand");
        end

        // LOAD mid-stream, then a rejected LOAD mid-expansion
        do_load(2'd0, k128, 40, 1'b0, "pre-abort");
        REVERS = 1'b0;
        start = 1'b1;
        rk_ready = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        check("mid-stream valid", 128'({rk_valid, rk_round}), 128'({1'b1, 4'd3}));
        kr = {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
        mode = 2'd2;
        key = kr;
        LOAD = 1'b1;
        @(posedge CLK); #1;
        LOAD = 1'b0;
        rk_ready = 1'b0;
        check("abort stream", 128'({rk_valid, key_ready, busy}), 128'(3'b001));
        repeat (5) begin @(posedge CLK); #1; end
        mode = 2'd3;
        LOAD = 1'b1;
        @(posedge CLK); #1;
        LOAD = 1'b0;
        check("bad load", 128'({err, key_ready, busy, rk_valid}), 128'(4'b1000));
        start = 1'b1;
        repeat (3) begin
            @(posedge CLK); #1;
            check("start ignored", 128'({err, key_ready, busy, rk_valid}), 128'(4'b1000));
        end
        start = 1'b0;
        do_load(2'd0, kr, 40, 1'b0, "recover");
        do_stream(1'b0, 2, "recover");

        // asynchronous reset mid-expansion
        mode = 2'd0;
        key = kr;
        LOAD = 1'b1;
        @(posedge CLK); #1;
        LOAD = 1'b0;
        repeat (10) begin @(posedge CLK); #1; end
        check("pre-reset busy", 128'(busy), 128'(1));
        RST_N = 1'b0;
        #1;
        check_all_zero("async reset");
        @(posedge CLK); #1;
        RST_N = 1'b1;
        do_load(2'd2, k256, 52, 1'b0, "post-reset");
        do_stream(1'b0, 0, "post-reset");
        check("post-reset r14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
